fft_bfly_datapath: RTL and testbench

- Four-lane radix-2 decimation-in-frequency (DIF) butterfly datapath for the FFT engine.
- Each cycle it accepts two 128-bit words. Each word holds four complex 16+16-bit samples.
- Per lane it computes a scaled sum and difference, then multiplies the difference by a twiddle factor from an internal ROM.
- It sits between the sample-memory read port and the write-back port. Addresses are delayed in step with the data so results are written back in place.

---
 rtl/fft_bfly_datapath.sv | 174 +++++++++++++++++
 tb/tb_fft_bfly_datapath.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_datapath.sv
// Four-lane radix-2 DIF butterfly with twiddle multiply; fixed latency BUTTERFLY_DELAY+MULT_DELAY.
// One word pair per cycle with no backpressure; valid, addresses and data advance in lockstep.
module fft_bfly_datapath #(
  parameter int BUTTERFLY_DELAY = 2,
  parameter int MULT_DELAY      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [127:0] i_data1,
  input  logic [127:0] i_data2,
  input  logic [7:0]   i_addr1,
  input  logic [7:0]   i_addr2,
  input  logic [9:0]   i_stride,
  input  logic [8:0]   i_twiddle_offset1,
  input  logic [8:0]   i_twiddle_offset2,
  input  logic [8:0]   i_twiddle_offset3,
  input  logic [8:0]   i_twiddle_offset4,
  output logic [127:0] o_data1,
  output logic [127:0] o_data2,
  output logic [7:0]   o_addr1,
  output logic [7:0]   o_addr2,
  output logic         o_valid
);

  localparam int L = BUTTERFLY_DELAY + MULT_DELAY;

  // pi in Q60 fixed point; the ROM is built from an integer Taylor series at elaboration.
  localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

  function automatic logic [31:0] twiddle_entry(input int k);
    logic signed [127:0] kk, th, x2, c, s, tc, ts, den, one, half, re, im;
    logic                neg;
    neg  = (k > 256);
    kk   = neg ? 128'(512 - k) : 128'(k);
    one  = 128'sd1 <<< 60;
    half = 128'sd1 <<< 59;
    th   = (PI_Q60 * kk) >>> 9;
    x2   = (th * th) >>> 60;
    c    = one;
    s    = th;
    tc   = one;
    ts   = th;
    for (int n = 1; n <= 15; n++) begin
      den = 128'((2 * n - 1) * (2 * n));
      tc  = -(((tc * x2) >>> 60) / den);
      c   = c + tc;
      den = 128'((2 * n) * (2 * n + 1));
      ts  = -(((ts * x2) >>> 60) / den);
      s   = s + ts;
    end
    re = (c * 128'sd32767 + half) >>> 60;
    if (neg) re = -re;
    im = -((s * 128'sd32767 + half) >>> 60);
    return {re[15:0], im[15:0]};
  endfunction

  // (a +/- b) >>> 1 in 17 bits; the halved result always fits back in 16.
  function automatic logic [15:0] half_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub);
    logic signed [16:0] r;
    if (sub) r = $signed({a[15], a}) - $signed({b[15], b});
    else     r = $signed({a[15], a}) + $signed({b[15], b});
    return r[16:1];
  endfunction

  function automatic logic [15:0] round_sat(input logic signed [32:0] acc);
    logic signed [32:0] r;
    r = (acc + 33'sd16384) >>> 15;
    if (r > 33'sd32767)       return 16'h7FFF;
    else if (r < -33'sd32768) return 16'h8000;
    else                      return r[15:0];
  endfunction

  function automatic logic [31:0] cmul_lane(input logic [31:0] d, input logic [31:0] w);
    logic signed [32:0] acc_re, acc_im;
    acc_re = 33'($signed(d[31:16])) * 33'($signed(w[31:16]))
           - 33'($signed(d[15:0]))  * 33'($signed(w[15:0]));
    acc_im = 33'($signed(d[31:16])) * 33'($signed(w[15:0]))
           + 33'($signed(d[15:0]))  * 33'($signed(w[31:16]));
    return {round_sat(acc_re), round_sat(acc_im)};
  endfunction

  logic [511:0][31:0] rom;

  for (genvar k = 0; k < 512; k++) begin : g_rom
    localparam logic [31:0] W = twiddle_entry(k);
    assign rom[k] = W;
  end

  logic [3:0][8:0] offs;
  logic [127:0]    sum_c, dif_c, tw_c, prod_c;

  assign offs = {i_twiddle_offset4, i_twiddle_offset3, i_twiddle_offset2, i_twiddle_offset1};

  logic [127:0] sum_pipe [L];
  logic [127:0] dif_pipe [BUTTERFLY_DELAY];
  logic [127:0] tw_pipe  [BUTTERFLY_DELAY];
  logic [127:0] prod_pipe [MULT_DELAY];
  logic [7:0]   addr1_pipe [L];
  logic [7:0]   addr2_pipe [L];
  logic [9:0]   stride_unused [L];
  logic [L-1:0] vld_pipe;

  always_comb begin
    sum_c = '0;
    dif_c = '0;
    tw_c  = '0;
    for (int i = 0; i < 4; i++) begin
      sum_c[32*i +: 32] = {half_op(i_data1[32*i+16 +: 16], i_data2[32*i+16 +: 16], 1'b0),
                           half_op(i_data1[32*i +: 16],    i_data2[32*i +: 16],    1'b0)};
      dif_c[32*i +: 32] = {half_op(i_data1[32*i+16 +: 16], i_data2[32*i+16 +: 16], 1'b1),
                           half_op(i_data1[32*i +: 16],    i_data2[32*i +: 16],    1'b1)};
      tw_c[32*i +: 32]  = rom[offs[i]];
    end
  end

  always_comb begin
    prod_c = '0;
    for (int i = 0; i < 4; i++) begin
      prod_c[32*i +: 32] = cmul_lane(dif_pipe[BUTTERFLY_DELAY-1][32*i +: 32],
                                     tw_pipe[BUTTERFLY_DELAY-1][32*i +: 32]);
    end
  end

  // Valid is shifted only from i_valid, so unknown data during bubbles cannot reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int j = 0; j < L; j++) begin
        sum_pipe[j]      <= '0;
        addr1_pipe[j]    <= '0;
        addr2_pipe[j]    <= '0;
        stride_unused[j] <= '0;
      end
      for (int j = 0; j < BUTTERFLY_DELAY; j++) begin
        dif_pipe[j] <= '0;
        tw_pipe[j]  <= '0;
      end
      for (int j = 0; j < MULT_DELAY; j++) begin
        prod_pipe[j] <= '0;
      end
    end else begin
      vld_pipe         <= {vld_pipe[L-2:0], i_valid};
      sum_pipe[0]      <= sum_c;
      addr1_pipe[0]    <= i_addr1;
      addr2_pipe[0]    <= i_addr2;
      stride_unused[0] <= i_stride;
      for (int j = 1; j < L; j++) begin
        sum_pipe[j]      <= sum_pipe[j-1];
        addr1_pipe[j]    <= addr1_pipe[j-1];
        addr2_pipe[j]    <= addr2_pipe[j-1];
        stride_unused[j] <= stride_unused[j-1];
      end
      dif_pipe[0] <= dif_c;
      tw_pipe[0]  <= tw_c;
      for (int j = 1; j < BUTTERFLY_DELAY; j++) begin
        dif_pipe[j] <= dif_pipe[j-1];
        tw_pipe[j]  <= tw_pipe[j-1];
      end
      prod_pipe[0] <= prod_c;
      for (int j = 1; j < MULT_DELAY; j++) begin
        prod_pipe[j] <= prod_pipe[j-1];
      end
    end
  end

  assign o_data1 = sum_pipe[L-1];
  assign o_data2 = prod_pipe[MULT_DELAY-1];
  assign o_addr1 = addr1_pipe[L-1];
  assign o_addr2 = addr2_pipe[L-1];
  assign o_valid = vld_pipe[L-1];

endmodule

// File: tb/tb_fft_bfly_datapath.sv
// Directed bench for fft_bfly_datapath: hand-computed vectors plus a small reference model for streams.
module tb_fft_bfly_datapath;
  localparam int  L  = 5;
  localparam real PI = 3.14159265358979323846;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic [127:0] i_data1, i_data2;
  logic [7:0]   i_addr1, i_addr2;
  logic [9:0]   i_stride;
  logic [8:0]   i_twiddle_offset1, i_twiddle_offset2, i_twiddle_offset3, i_twiddle_offset4;
  logic [127:0] o_data1, o_data2;
  logic [7:0]   o_addr1, o_addr2;
  logic         o_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_bfly_datapath #(.BUTTERFLY_DELAY(2), .MULT_DELAY(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
    .i_data1(i_data1), .i_data2(i_data2), .i_addr1(i_addr1), .i_addr2(i_addr2),
    .i_stride(i_stride),
    .i_twiddle_offset1(i_twiddle_offset1), .i_twiddle_offset2(i_twiddle_offset2),
    .i_twiddle_offset3(i_twiddle_offset3), .i_twiddle_offset4(i_twiddle_offset4),
    .o_data1(o_data1), .o_data2(o_data2), .o_addr1(o_addr1), .o_addr2(o_addr2),
    .o_valid(o_valid)
  );

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  task automatic model(input logic [127:0] a, input logic [127:0] b, input logic [35:0] offs,
                       output logic [127:0] s, output logic [127:0] p);
    int ar, ai, br, bi, sr, si, dr, di, wr, wi, k;
    longint pr, pim;
    s = '0;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      ar = int'($signed(a[32*i+16 +: 16]));
      ai = int'($signed(a[32*i +: 16]));
      br = int'($signed(b[32*i+16 +: 16]));
      bi = int'($signed(b[32*i +: 16]));
      sr = (ar + br) >>> 1;
      si = (ai + bi) >>> 1;
      dr = (ar - br) >>> 1;
      di = (ai - bi) >>> 1;
      k  = int'(offs[9*i +: 9]);
      wr = rnd(32767.0 * $cos(PI * real'(k) / 512.0));
      wi = rnd(-32767.0 * $sin(PI * real'(k) / 512.0));
      pr  = (longint'(dr) * wr - longint'(di) * wi + 16384) >>> 15;
      pim = (longint'(dr) * wi + longint'(di) * wr + 16384) >>> 15;
      if (pr > 32767) pr = 32767; else if (pr < -32768) pr = -32768;
      if (pim > 32767) pim = 32767; else if (pim < -32768) pim = -32768;
      s[32*i +: 32] = {sr[15:0], si[15:0]};
      p[32*i +: 32] = {pr[15:0], pim[15:0]};
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [127:0] a, input logic [127:0] b, input logic [35:0] offs,
                       input logic [7:0] a1, input logic [7:0] a2, input logic vld);
    i_valid  = vld;
    i_data1  = a;
    i_data2  = b;
    i_addr1  = a1;
    i_addr2  = a2;
    i_stride = {2'b00, a1} ^ 10'h2A5;
    i_twiddle_offset1 = offs[8:0];
    i_twiddle_offset2 = offs[17:9];
    i_twiddle_offset3 = offs[26:18];
    i_twiddle_offset4 = offs[35:27];
  endtask

  // One valid pair for a single cycle, leaving the caller one negedge later.
  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [35:0] offs,
                      input logic [7:0] a1, input logic [7:0] a2);
    drive(a, b, offs, a1, a2, 1'b1);
    wait_neg(1);
    drive('0, '0, '0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive('0, '0, '0, 8'h00, 8'h00, 1'b0);
    wait_neg(2);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o_valid); end
    vectors++; if (o_data1 !== '0) begin miscompares++; $display("FAIL reset_data1 got %h want 0", o_data1); end
    vectors++; if (o_data2 !== '0) begin miscompares++; $display("FAIL reset_data2 got %h want 0", o_data2); end
    vectors++; if ({o_addr1, o_addr2} !== 16'h0) begin miscompares++; $display("FAIL reset_addr got %h/%h want 0", o_addr1, o_addr2); end
    rst_n = 1'b1;
    wait_neg(2);
  endtask

  task automatic test_basic;
    send(128'h20000000, 128'h10000000, 36'd0, 8'h11, 8'h22);
    wait_neg(L - 2);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b want 0", o_valid); end
    wait_neg(1);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", o_valid); end
    vectors++; if (o_data1 !== 128'h18000000) begin miscompares++; $display("FAIL basic_sum got %h want %h", o_data1, 128'h18000000); end
    vectors++; if (o_data2 !== 128'h08000000) begin miscompares++; $display("FAIL basic_diff got %h want %h", o_data2, 128'h08000000); end
    vectors++; if ({o_addr1, o_addr2} !== 16'h1122) begin miscompares++; $display("FAIL basic_addr got %h/%h want 11/22", o_addr1, o_addr2); end
    wait_neg(1);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL basic_after_valid got %b want 0", o_valid); end
  endtask

  task automatic test_twiddle_neg_j;
    send(128'h20000000, 128'h10000000, 36'd256, 8'h33, 8'h44);
    wait_neg(L - 1);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL negj_valid got %b want 1", o_valid); end
    vectors++; if (o_data1 !== 128'h18000000) begin miscompares++; $display("FAIL negj_sum got %h want %h", o_data1, 128'h18000000); end
    vectors++; if (o_data2 !== 128'h0000F800) begin miscompares++; $display("FAIL negj_diff got %h want %h", o_data2, 128'h0000F800); end
    wait_neg(1);
  endtask

  task automatic test_lanes;
    logic [127:0] a, b, es, ep;
    logic [35:0]  offs;
    a    = 128'h3A5C1F00_90007FFF_01234567_C0004000;
    b    = 128'h11110EEE_7FFF8001_FEDCBA98_3FFFC000;
    offs = {9'd384, 9'd256, 9'd128, 9'd0};
    model(a, b, offs, es, ep);
    send(a, b, offs, 8'h5A, 8'hA5);
    wait_neg(L - 1);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL lanes_valid got %b want 1", o_valid); end
    vectors++; if (o_data1 !== es) begin miscompares++; $display("FAIL lanes_sum got %h want %h", o_data1, es); end
    vectors++; if (o_data2 !== ep) begin miscompares++; $display("FAIL lanes_diff got %h want %h", o_data2, ep); end
    wait_neg(1);
  endtask

  // Lane0/1: offset 0 extremes; lanes 2/3: offset 128 driving negative and positive saturation.
  task automatic test_extremes;
    send(128'h7FFF7FFF_80008000_80008000_80008000,
         128'h80008000_7FFF7FFF_80008000_7FFF7FFF,
         {9'd128, 9'd128, 9'd0, 9'd0}, 8'h01, 8'h02);
    wait_neg(L - 1);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL ext_valid got %b want 1", o_valid); end
    vectors++; if (o_data1 !== 128'hFFFFFFFF_FFFFFFFF_80008000_FFFFFFFF) begin
      miscompares++; $display("FAIL ext_sum got %h want FFFFFFFFFFFFFFFF80008000FFFFFFFF", o_data1); end
    vectors++; if (o_data2 !== 128'h7FFF0000_80000000_00000000_80018001) begin
      miscompares++; $display("FAIL ext_diff got %h want 7FFF00008000000000000000_80018001", o_data2); end
    wait_neg(1);
  endtask

  task automatic test_back_to_back;
    localparam int NIN = 75;
    localparam int N   = NIN + L + 2;
    logic [127:0] hs [N];
    logic [127:0] hp [N];
    logic [7:0]   ha [N];
    logic         hv [N];
    logic [127:0] a, b, es, ep;
    logic [35:0]  offs;
    logic         vld;
    int           pulses;
    int           idx;
    pulses = 0;
    idx    = 0;
    for (int c = 0; c < N; c++) begin
      if (c >= L && hv[c-L]) begin
        pulses++;
        vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid c=%0d got %b want 1", c, o_valid); end
        vectors++; if (o_data1 !== hs[c-L]) begin miscompares++; $display("FAIL stream_sum c=%0d got %h want %h", c, o_data1, hs[c-L]); end
        vectors++; if (o_data2 !== hp[c-L]) begin miscompares++; $display("FAIL stream_diff c=%0d got %h want %h", c, o_data2, hp[c-L]); end
        vectors++; if ({o_addr1, o_addr2} !== {ha[c-L], ~ha[c-L]}) begin
          miscompares++; $display("FAIL stream_addr c=%0d got %h/%h want %h/%h", c, o_addr1, o_addr2, ha[c-L], ~ha[c-L]); end
      end else begin
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL stream_bubble c=%0d got %b want 0", c, o_valid); end
      end
      a    = {$urandom, $urandom, $urandom, $urandom};
      b    = {$urandom, $urandom, $urandom, $urandom};
      offs = {$urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511)};
      vld  = (c < 64) || (c >= 67 && c < NIN);
      model(a, b, offs, es, ep);
      hv[c] = vld;
      hs[c] = es;
      hp[c] = ep;
      ha[c] = idx[7:0];
      drive(a, b, offs, idx[7:0], ~idx[7:0], vld);
      if (vld) idx++;
      wait_neg(1);
    end
    drive('0, '0, '0, 8'h00, 8'h00, 1'b0);
    vectors++; if (pulses !== 72) begin miscompares++; $display("FAIL stream_count got %0d want 72", pulses); end
  endtask

  task automatic test_reset_midstream;
    for (int c = 0; c < 6; c++) begin
      drive(128'h20000000, 128'h10000000, 36'd0, 8'h70 + 8'(c), 8'h80, 1'b1);
      wait_neg(1);
    end
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full_valid got %b want 1", o_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", o_valid); end
    vectors++; if ({o_data1, o_data2} !== 256'h0) begin miscompares++; $display("FAIL mid_rst_data got %h/%h want 0", o_data1, o_data2); end
    vectors++; if ({o_addr1, o_addr2} !== 16'h0) begin miscompares++; $display("FAIL mid_rst_addr got %h/%h want 0", o_addr1, o_addr2); end
    wait_neg(2);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mid_hold_valid got %b want 0", o_valid); end
    rst_n = 1'b1;
    drive('0, '0, '0, 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < L + 1; c++) begin
      wait_neg(1);
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale c=%0d got %b want 0", c, o_valid); end
    end
    send(128'h20000000, 128'h10000000, 36'd256, 8'h9C, 8'hC9);
    wait_neg(L - 2);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mid_new_early got %b want 0", o_valid); end
    wait_neg(1);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL mid_new_valid got %b want 1", o_valid); end
    vectors++; if (o_data1 !== 128'h18000000) begin miscompares++; $display("FAIL mid_new_sum got %h want %h", o_data1, 128'h18000000); end
    vectors++; if (o_data2 !== 128'h0000F800) begin miscompares++; $display("FAIL mid_new_diff got %h want %h", o_data2, 128'h0000F800); end
    vectors++; if ({o_addr1, o_addr2} !== 16'h9CC9) begin miscompares++; $display("FAIL mid_new_addr got %h/%h want 9C/C9", o_addr1, o_addr2); end
    wait_neg(1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_twiddle_neg_j;
    test_lanes;
    test_extremes;
    test_back_to_back;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
